// File: rtl/sd_cic_decim.sv
// Third-order (parameterisable) CIC decimator for the sd2 sigma-delta bitstream.
// Integrators run at the bit rate, combs run once per R clocks, and the result is scaled and saturated.
module sd_cic_decim #(
    parameter int ORDER  = 3,
    parameter int LOG2_R = 6,
    parameter int OUT_BW = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     bs_in,
    output logic signed [OUT_BW-1:0] pcm_out,
    output logic                     pcm_valid,
    output logic [LOG2_R-1:0]        dec_cnt
);

    localparam int ACC_BW  = 2 + ORDER * LOG2_R;
    localparam int SHIFT   = ORDER * LOG2_R + 1 - OUT_BW;
    localparam int WIDE_BW = ACC_BW + OUT_BW;

    typedef logic signed [ACC_BW-1:0] acc_t;

    localparam acc_t                      X_POS   = {{(ACC_BW-1){1'b0}}, 1'b1};
    localparam acc_t                      X_NEG   = '1;
    localparam logic [LOG2_R-1:0]         CNT_MAX = '1;
    localparam logic signed [WIDE_BW-1:0] SAT_MAX = WIDE_BW'((2 ** (OUT_BW - 1)) - 1);
    localparam logic signed [WIDE_BW-1:0] SAT_MIN = ~SAT_MAX;

    acc_t integ_q [ORDER];
    acc_t integ_d [ORDER];
    // comb_q[0] is the decimated capture; comb_q[k] is the output of comb stage k
    acc_t comb_q  [ORDER];
    acc_t comb_d  [ORDER];
    acc_t dly_q   [ORDER];
    acc_t dly_d   [ORDER];

    logic [ORDER-1:0]         stage_vld_q, stage_vld_d;
    logic [LOG2_R-1:0]        dec_cnt_q, dec_cnt_d;
    logic signed [OUT_BW-1:0] pcm_out_q, pcm_out_d;
    logic                     pcm_valid_q, pcm_valid_d;

    acc_t                      x;
    acc_t                      comb_last;
    logic                      strobe;
    logic signed [WIDE_BW-1:0] comb_wide;
    logic signed [WIDE_BW-1:0] scaled;
    logic signed [OUT_BW-1:0]  sat_val;

    assign comb_wide = {{OUT_BW{comb_last[ACC_BW-1]}}, comb_last};

    generate
        if (SHIFT >= 0) begin : g_shift_right
            assign scaled = comb_wide >>> SHIFT;
        end else begin : g_shift_left
            assign scaled = comb_wide <<< (-SHIFT);
        end
    endgenerate

    always_comb begin
        sat_val = scaled[OUT_BW-1:0];
        if (scaled > SAT_MAX) begin
            sat_val = SAT_MAX[OUT_BW-1:0];
        end else if (scaled < SAT_MIN) begin
            sat_val = SAT_MIN[OUT_BW-1:0];
        end
    end

    // Integrators wrap freely; the matching combs cancel the overflow exactly.
    always_comb begin
        x          = bs_in ? X_POS : X_NEG;
        strobe     = (dec_cnt_q == CNT_MAX);
        dec_cnt_d  = dec_cnt_q + 1'b1;
        integ_d[0] = integ_q[0] + x;
        for (int k = 1; k < ORDER; k++) begin
            integ_d[k] = integ_q[k] + integ_q[k-1];
        end

        comb_d         = comb_q;
        dly_d          = dly_q;
        stage_vld_d[0] = strobe;
        for (int k = 1; k < ORDER; k++) begin
            stage_vld_d[k] = stage_vld_q[k-1];
        end
        if (strobe) begin
            comb_d[0] = integ_q[ORDER-1];
        end
        for (int k = 1; k < ORDER; k++) begin
            if (stage_vld_q[k-1]) begin
                comb_d[k]  = comb_q[k-1] - dly_q[k-1];
                dly_d[k-1] = comb_q[k-1];
            end
        end

        // The final comb feeds the output register directly to save a pipeline cycle.
        comb_last   = comb_q[ORDER-1] - dly_q[ORDER-1];
        pcm_valid_d = stage_vld_q[ORDER-1];
        pcm_out_d   = pcm_out_q;
        if (stage_vld_q[ORDER-1]) begin
            dly_d[ORDER-1] = comb_q[ORDER-1];
            pcm_out_d      = sat_val;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < ORDER; k++) begin
                integ_q[k] <= '0;
                comb_q[k]  <= '0;
                dly_q[k]   <= '0;
            end
            stage_vld_q <= '0;
            dec_cnt_q   <= '0;
            pcm_out_q   <= '0;
            pcm_valid_q <= 1'b0;
        end else begin
            integ_q     <= integ_d;
            comb_q      <= comb_d;
            dly_q       <= dly_d;
            stage_vld_q <= stage_vld_d;
            dec_cnt_q   <= dec_cnt_d;
            pcm_out_q   <= pcm_out_d;
            pcm_valid_q <= pcm_valid_d;
        end
    end

    assign pcm_out   = pcm_out_q;
    assign pcm_valid = pcm_valid_q;
    assign dec_cnt   = dec_cnt_q;

endmodule

// File: tb/tb_sd_cic_decim.sv
// Self-checking bench for sd_cic_decim: pattern inputs, a behavioural second-order modulator loop,
// strobe cadence and reset behaviour, all checked through a scoreboard of expected samples.
module tb_sd_cic_decim;

    localparam int ORDER    = 3;
    localparam int LOG2_R   = 6;
    localparam int OUT_BW   = 16;
    localparam int R        = 1 << LOG2_R;
    localparam int FULL_POS = (2 ** (OUT_BW - 1)) - 1;
    localparam int FULL_NEG = -(2 ** (OUT_BW - 1));

    localparam int MODE_ONES  = 0;
    localparam int MODE_ZEROS = 1;
    localparam int MODE_ALT   = 2;
    localparam int MODE_3Q    = 3;
    localparam int MODE_LOOP  = 4;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     bs_in = 1'b0;
    logic signed [OUT_BW-1:0] pcm_out;
    logic                     pcm_valid;
    logic [LOG2_R-1:0]        dec_cnt;

    typedef struct packed {
        logic check;
        int   value;
        int   tol;
    } exp_t;

    exp_t  sb_q [$];
    exp_t  sb_entry;
    string current_tag = "init";
    int    tests = 0;
    int    errors = 0;
    int    edge_cnt = 0;
    int    last_valid = -1;

    longint sd_v1 = 0;
    longint sd_v2 = 0;
    logic   sd_bs = 1'b0;

    sd_cic_decim #(
        .ORDER (ORDER),
        .LOG2_R(LOG2_R),
        .OUT_BW(OUT_BW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bs_in    (bs_in),
        .pcm_out  (pcm_out),
        .pcm_valid(pcm_valid),
        .dec_cnt  (dec_cnt)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports any value outside expected +/- tol.
    task automatic checkOutput(input string tag, input int observed, input int expected, input int tol);
        tests++;
        if (observed > expected + tol || observed < expected - tol) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (tol %0d)", tag, observed, expected, tol);
        end
    endtask

    // Behavioural second-order sigma-delta modulator (same word format as pcm_out).
    function automatic logic sdStep(input int u);
        longint fb;
        fb    = sd_bs ? 64'sd32768 : -64'sd32768;
        sd_v1 = sd_v1 + u - fb;
        sd_v2 = sd_v2 + sd_v1 - fb;
        sd_bs = (sd_v2 >= 0);
        return sd_bs;
    endfunction

    function automatic logic patternBit(input int mode, input int phase);
        case (mode)
            MODE_ONES:  return 1'b1;
            MODE_ZEROS: return 1'b0;
            MODE_ALT:   return ((phase % 2) == 0);
            MODE_3Q:    return ((phase % 4) != 3);
            default:    return 1'b0;
        endcase
    endfunction

    // Clock edges since the last reset edge; the reset edge itself is edge 0.
    always @(posedge clk) begin
        edge_cnt <= rst ? 0 : edge_cnt + 1;
    end

    // Monitor, 2 time units after each rising edge: reset state, strobe cadence, and scoreboard pops.
    always @(posedge clk) begin
        #2;
        if (rst) begin
            last_valid = -1;
            checkOutput("rst_pcm_out", int'(pcm_out), 0, 0);
            checkOutput("rst_pcm_valid", int'(pcm_valid), 0, 0);
            checkOutput("rst_dec_cnt", int'(dec_cnt), 0, 0);
        end else if (pcm_valid) begin
            if (last_valid < 0) begin
                checkOutput({current_tag, "_first_valid_cycle"}, edge_cnt, R + ORDER, 0);
            end else begin
                checkOutput({current_tag, "_valid_spacing"}, edge_cnt - last_valid, R, 0);
            end
            last_valid = edge_cnt;
            checkOutput({current_tag, "_dec_phase"}, int'(dec_cnt), ORDER, 0);
            if (sb_q.size() == 0) begin
                checkOutput({current_tag, "_unexpected_valid"}, sb_q.size(), 1, 0);
            end else begin
                sb_entry = sb_q.pop_front();
                if (sb_entry.check) begin
                    checkOutput({current_tag, "_pcm"}, int'(pcm_out), sb_entry.value, sb_entry.tol);
                end
            end
        end
    end

    // Reset for rst_cycles with random bits, queue n_samples expectations (first ORDER are transient),
    // then drive the chosen pattern for exactly long enough to produce those samples plus extra cycles.
    task automatic applyStimulus(input string tag, input int mode, input int n_samples,
                                 input int exp_val, input int tol, input int rst_cycles,
                                 input int extra_cycles);
        @(negedge clk);
        rst = 1'b1;
        repeat (rst_cycles) begin
            bs_in = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        current_tag = tag;
        sb_q.delete();
        for (int i = 0; i < n_samples; i++) begin
            sb_q.push_back('{check: (i >= ORDER), value: exp_val, tol: tol});
        end
        rst = 1'b0;
        for (int phase = 0; phase < n_samples * R + ORDER + extra_cycles; phase++) begin
            if (mode == MODE_LOOP) begin
                bs_in = sdStep(10000);
            end else begin
                bs_in = patternBit(mode, phase);
            end
            @(negedge clk);
        end
        checkOutput({tag, "_drain"}, sb_q.size(), 0, 0);
    endtask

    initial begin
        applyStimulus("all_ones",      MODE_ONES,  10,  FULL_POS, 0,  5, 0);
        applyStimulus("all_zeros",     MODE_ZEROS, 10,  FULL_NEG, 0,  5, 0);
        applyStimulus("zero_mean",     MODE_ALT,   10,  0,        0,  5, 0);
        applyStimulus("three_quarter", MODE_3Q,    320, 16384,    0,  5, 0);
        applyStimulus("loop_pre",      MODE_LOOP,  5,   10000,    64, 1, 20);
        applyStimulus("loop_restart",  MODE_LOOP,  40,  10000,    64, 1, 0);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
